// File: rtl/cdb_arbiter_param.sv
// Common-data-bus arbiter: per-unit result FIFOs feeding one registered
// CDB broadcast per cycle, fixed-priority or round-robin grant.
module cdb_arbiter_param #(
  parameter int NUM_UNITS = 2,
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 4,
  parameter int RR_MODE   = 1,
  localparam int SRC_W  = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1,
  localparam int PEND_W = $clog2(NUM_UNITS * DEPTH + 1)
) (
  input  logic                        clock_i,
  input  logic                        reset_i,
  input  logic [NUM_UNITS-1:0]        fu_valid_i,
  input  logic [NUM_UNITS*DATA_W-1:0] fu_data_i,
  output logic [NUM_UNITS-1:0]        fu_ready_o,
  input  logic                        cdb_stall_i,
  output logic                        cdb_valid_o,
  output logic [DATA_W-1:0]           cdb_data_o,
  output logic [SRC_W-1:0]            cdb_src_o,
  output logic [PEND_W-1:0]           pending_o
);

  logic [NUM_UNITS-1:0] req;
  logic [CNT_W-1:0]     cnt_arr  [NUM_UNITS];
  logic [DATA_W-1:0]    head_arr [NUM_UNITS];

  logic                 gnt_vld;
  logic [SRC_W-1:0]     gnt_idx;
  logic [SRC_W-1:0]     rr_cand;

  logic                 cdb_valid_q, cdb_valid_d;
  logic [DATA_W-1:0]    cdb_data_q, cdb_data_d;
  logic [SRC_W-1:0]     cdb_src_q, cdb_src_d;
  logic [SRC_W-1:0]     last_q, last_d;
  logic [PEND_W-1:0]    pend;

  for (genvar g = 0; g < NUM_UNITS; g++) begin : gen_ch
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              push;
    logic              pop;

    assign fu_ready_o[g] = (cnt_q != CNT_W'(DEPTH));
    assign req[g]        = (cnt_q != '0);
    assign push          = fu_valid_i[g] & fu_ready_o[g];
    assign pop           = gnt_vld & (gnt_idx == SRC_W'(g));
    assign cnt_arr[g]    = cnt_q;
    assign head_arr[g]   = mem_q[head_q];

    // Next pointers/occupancy; push and pop cancel in the count.
    always_comb begin
      head_d = head_q + PTR_W'(pop);
      tail_d = tail_q + PTR_W'(push);
      cnt_d  = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end

    // Channel bookkeeping, cleared on reset so queued entries vanish.
    always_ff @(posedge clock_i) begin
      if (reset_i) begin
        head_q <= '0;
        tail_q <= '0;
        cnt_q  <= '0;
      end else begin
        head_q <= head_d;
        tail_q <= tail_d;
        cnt_q  <= cnt_d;
      end
    end

    // Storage needs no reset; occupancy gates every read.
    always_ff @(posedge clock_i) begin
      if (push) mem_q[tail_q] <= fu_data_i[g*DATA_W +: DATA_W];
    end
  end

  // Pick one requesting channel; nothing is granted under stall.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    rr_cand = '0;
    if (!cdb_stall_i) begin
      if (RR_MODE == 0) begin
        for (int i = NUM_UNITS - 1; i >= 0; i--) begin
          if (req[i]) begin
            gnt_vld = 1'b1;
            gnt_idx = SRC_W'(i);
          end
        end
      end else begin
        for (int k = NUM_UNITS; k >= 1; k--) begin
          rr_cand = SRC_W'((int'(last_q) + k) % NUM_UNITS);
          if (req[rr_cand]) begin
            gnt_vld = 1'b1;
            gnt_idx = rr_cand;
          end
        end
      end
    end
  end

  // Total queued entries across all channels.
  always_comb begin
    pend = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      pend = pend + PEND_W'(cnt_arr[i]);
    end
  end

  // Broadcast next-state: data/src hold when no grant.
  always_comb begin
    cdb_valid_d = gnt_vld;
    cdb_data_d  = cdb_data_q;
    cdb_src_d   = cdb_src_q;
    last_d      = last_q;
    if (gnt_vld) begin
      cdb_data_d = head_arr[gnt_idx];
      cdb_src_d  = gnt_idx;
      last_d     = gnt_idx;
    end
  end

  // Registered CDB outputs and round-robin pointer.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cdb_valid_q <= 1'b0;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
      last_q      <= SRC_W'(NUM_UNITS - 1);
    end else begin
      cdb_valid_q <= cdb_valid_d;
      cdb_data_q  <= cdb_data_d;
      cdb_src_q   <= cdb_src_d;
      last_q      <= last_d;
    end
  end

  assign cdb_valid_o = cdb_valid_q;
  assign cdb_data_o  = cdb_data_q;
  assign cdb_src_o   = cdb_src_q;
  assign pending_o   = pend;

endmodule

// File: tb/tb_cdb_arbiter_param.sv
// Directed bench for cdb_arbiter_param: round-robin and fixed-priority
// instances share stimulus; table vectors plus multi-cycle sequences.
module tb_cdb_arbiter_param;

  logic        clk;
  logic        rst;
  logic [1:0]  vld;
  logic [15:0] d0, d1;
  logic        stall;

  logic [1:0]  rr_rdy, fp_rdy;
  logic        rr_v, fp_v;
  logic [15:0] rr_d, fp_d;
  logic        rr_s, fp_s;
  logic [3:0]  rr_p, fp_p;

  int checks;
  int failures;

  cdb_arbiter_param #(
    .NUM_UNITS(2), .DATA_W(16), .DEPTH(4), .RR_MODE(1)
  ) dut_rr (
    .clock_i    (clk),
    .reset_i    (rst),
    .fu_valid_i (vld),
    .fu_data_i  ({d1, d0}),
    .fu_ready_o (rr_rdy),
    .cdb_stall_i(stall),
    .cdb_valid_o(rr_v),
    .cdb_data_o (rr_d),
    .cdb_src_o  (rr_s),
    .pending_o  (rr_p)
  );

  cdb_arbiter_param #(
    .NUM_UNITS(2), .DATA_W(16), .DEPTH(4), .RR_MODE(0)
  ) dut_fp (
    .clock_i    (clk),
    .reset_i    (rst),
    .fu_valid_i (vld),
    .fu_data_i  ({d1, d0}),
    .fu_ready_o (fp_rdy),
    .cdb_stall_i(stall),
    .cdb_valid_o(fp_v),
    .cdb_data_o (fp_d),
    .cdb_src_o  (fp_s),
    .pending_o  (fp_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [1:0]  vld;
    logic [15:0] d0;
    logic [15:0] d1;
    logic        stall;
    logic        e_v;
    logic [15:0] e_d;
    logic        e_s;
    logic [3:0]  e_p;
    logic        f_v;
    logic [15:0] f_d;
    logic        f_s;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic both(input string name, input logic v,
                      input logic [15:0] d, input logic s,
                      input logic [3:0] p);
    chk({"rr_", name, "_v"}, 32'(rr_v), 32'(v));
    chk({"fp_", name, "_v"}, 32'(fp_v), 32'(v));
    chk({"rr_", name, "_d"}, 32'(rr_d), 32'(d));
    chk({"fp_", name, "_d"}, 32'(fp_d), 32'(d));
    chk({"rr_", name, "_s"}, 32'(rr_s), 32'(s));
    chk({"fp_", name, "_s"}, 32'(fp_s), 32'(s));
    chk({"rr_", name, "_p"}, 32'(rr_p), 32'(p));
    chk({"fp_", name, "_p"}, 32'(fp_p), 32'(p));
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    tbl[0]  = '{0, 2'b01, 16'h1234, 16'h0000, 0,
                0, 16'h0000, 0, 4'd1, 0, 16'h0000, 0};
    tbl[1]  = '{0, 2'b00, 16'h0000, 16'h0000, 0,
                1, 16'h1234, 0, 4'd0, 1, 16'h1234, 0};
    tbl[2]  = '{0, 2'b00, 16'h0000, 16'h0000, 0,
                0, 16'h1234, 0, 4'd0, 0, 16'h1234, 0};
    tbl[3]  = '{1, 2'b00, 16'h0000, 16'h0000, 0,
                0, 16'h0000, 0, 4'd0, 0, 16'h0000, 0};
    tbl[4]  = '{0, 2'b11, 16'hA000, 16'hB000, 0,
                0, 16'h0000, 0, 4'd2, 0, 16'h0000, 0};
    tbl[5]  = '{0, 2'b11, 16'hA001, 16'hB001, 0,
                1, 16'hA000, 0, 4'd3, 1, 16'hA000, 0};
    tbl[6]  = '{0, 2'b11, 16'hA002, 16'hB002, 0,
                1, 16'hB000, 1, 4'd4, 1, 16'hA001, 0};
    tbl[7]  = '{0, 2'b00, 16'h0000, 16'h0000, 0,
                1, 16'hA001, 0, 4'd3, 1, 16'hA002, 0};
    tbl[8]  = '{0, 2'b00, 16'h0000, 16'h0000, 0,
                1, 16'hB001, 1, 4'd2, 1, 16'hB000, 1};
    tbl[9]  = '{0, 2'b00, 16'h0000, 16'h0000, 0,
                1, 16'hA002, 0, 4'd1, 1, 16'hB001, 1};
    tbl[10] = '{0, 2'b00, 16'h0000, 16'h0000, 0,
                1, 16'hB002, 1, 4'd0, 1, 16'hB002, 1};
    tbl[11] = '{0, 2'b00, 16'h0000, 16'h0000, 0,
                0, 16'hB002, 1, 4'd0, 0, 16'hB002, 1};

    rst   = 1'b1;
    vld   = 2'b00;
    d0    = '0;
    d1    = '0;
    stall = 1'b0;
    tick();
    tick();
    both("reset", 0, 16'h0000, 0, 4'd0);
    chk("rr_reset_rdy", 32'(rr_rdy), 32'h3);
    chk("fp_reset_rdy", 32'(fp_rdy), 32'h3);
    rst = 1'b0;

    // single push + RR/fixed ordering
    for (int i = 0; i < 12; i++) begin
      rst   = tbl[i].rst;
      vld   = tbl[i].vld;
      d0    = tbl[i].d0;
      d1    = tbl[i].d1;
      stall = tbl[i].stall;
      tick();
      chk($sformatf("v%0d_rr_v", i), 32'(rr_v), 32'(tbl[i].e_v));
      chk($sformatf("v%0d_rr_d", i), 32'(rr_d), 32'(tbl[i].e_d));
      chk($sformatf("v%0d_rr_s", i), 32'(rr_s), 32'(tbl[i].e_s));
      chk($sformatf("v%0d_rr_p", i), 32'(rr_p), 32'(tbl[i].e_p));
      chk($sformatf("v%0d_rr_r", i), 32'(rr_rdy), 32'h3);
      chk($sformatf("v%0d_fp_v", i), 32'(fp_v), 32'(tbl[i].f_v));
      chk($sformatf("v%0d_fp_d", i), 32'(fp_d), 32'(tbl[i].f_d));
      chk($sformatf("v%0d_fp_s", i), 32'(fp_s), 32'(tbl[i].f_s));
      chk($sformatf("v%0d_fp_p", i), 32'(fp_p), 32'(tbl[i].e_p));
    end
    rst = 1'b0;
    vld = 2'b00;

    // full channel under held stall
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vld = 2'b10;
      d1  = 16'hC100 + 16'(i);
      tick();
      both($sformatf("full_push%0d", i), 0, 16'hB002, 1, 4'(i + 1));
    end
    chk("rr_full_rdy", 32'(rr_rdy), 32'h1);
    chk("fp_full_rdy", 32'(fp_rdy), 32'h1);
    d1 = 16'hC1FF;
    tick();
    both("full_reject", 0, 16'hB002, 1, 4'd4);
    chk("rr_reject_rdy", 32'(rr_rdy), 32'h1);
    vld   = 2'b00;
    stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      both($sformatf("full_drain%0d", i), 1, 16'hC100 + 16'(i), 1,
           4'(3 - i));
      if (i == 0) begin
        chk("rr_drain_rdy", 32'(rr_rdy), 32'h3);
        chk("fp_drain_rdy", 32'(fp_rdy), 32'h3);
      end
    end
    tick();
    both("full_idle", 0, 16'hC103, 1, 4'd0);

    // stall mid-stream
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vld = 2'b01;
      d0  = 16'hE000 + 16'(i);
      tick();
    end
    vld = 2'b00;
    both("mid_queued", 0, 16'hC103, 1, 4'd3);
    stall = 1'b0;
    tick();
    both("mid_b0", 1, 16'hE000, 0, 4'd2);
    stall = 1'b1;
    tick();
    both("mid_stall0", 0, 16'hE000, 0, 4'd2);
    tick();
    both("mid_stall1", 0, 16'hE000, 0, 4'd2);
    stall = 1'b0;
    tick();
    both("mid_b1", 1, 16'hE001, 0, 4'd1);
    tick();
    both("mid_b2", 1, 16'hE002, 0, 4'd0);
    tick();
    both("mid_idle", 0, 16'hE002, 0, 4'd0);

    // steady push+pop on unit 0
    for (int i = 0; i < 8; i++) begin
      vld = 2'b01;
      d0  = 16'hF000 + 16'(i);
      tick();
      if (i == 0) both("ss_first", 0, 16'hE002, 0, 4'd1);
      else both($sformatf("ss%0d", i), 1, 16'hF000 + 16'(i - 1), 0, 4'd1);
    end
    vld = 2'b00;
    tick();
    both("ss_last", 1, 16'hF007, 0, 4'd0);

    // reset with five entries pending
    stall = 1'b1;
    vld = 2'b11; d0 = 16'h7000; d1 = 16'h8000; tick();
    vld = 2'b11; d0 = 16'h7001; d1 = 16'h8001; tick();
    vld = 2'b01; d0 = 16'h7002; tick();
    both("pre_rst", 0, 16'hF007, 0, 4'd5);
    vld   = 2'b00;
    stall = 1'b0;
    rst   = 1'b1;
    tick();
    both("mid_rst", 0, 16'h0000, 0, 4'd0);
    chk("rr_mid_rst_rdy", 32'(rr_rdy), 32'h3);
    chk("fp_mid_rst_rdy", 32'(fp_rdy), 32'h3);
    rst = 1'b0;
    vld = 2'b11; d0 = 16'h9000; d1 = 16'h9100;
    tick();
    both("post_push", 0, 16'h0000, 0, 4'd2);
    vld = 2'b00;
    tick();
    both("post_b0", 1, 16'h9000, 0, 4'd1);
    tick();
    both("post_b1", 1, 16'h9100, 1, 4'd0);
    tick();
    both("post_idle", 0, 16'h9100, 1, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
